cordic_sequencer: RTL

//  Control FSM for the iterative CORDIC datapath (x/y/z registers, shifters, angle LUT, di control).

---
 rtl/cordic_ctrl_pkg.sv | 24 ++
 rtl/cordic_iter_index.sv | 46 ++++
 rtl/cordic_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/cordic_ctrl_pkg.sv
// rtl/cordic_ctrl_pkg.sv - shared states, coordinate codes and repeat indices for the CORDIC control path
package cordic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } seq_state_e;

  localparam logic [1:0] COORD_LIN     = 2'b00;
  localparam logic [1:0] COORD_CIRC    = 2'b01;
  localparam logic [1:0] COORD_HYP     = 2'b10;
  localparam logic [1:0] COORD_ILLEGAL = 2'b11;

  // Hyperbolic convergence needs these indices issued twice.
  localparam int HYP_REPEAT_A = 4;
  localparam int HYP_REPEAT_B = 13;

  function automatic logic is_hyp_repeat(input int idx);
    return (idx == HYP_REPEAT_A) || (idx == HYP_REPEAT_B);
  endfunction

endpackage

// File: rtl/cordic_iter_index.sv
// rtl/cordic_iter_index.sv - iteration index generator with hyperbolic repeat tracking
module cordic_iter_index
  import cordic_ctrl_pkg::*;
#(
  parameter int NUM_ITER  = 8,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           coord,
  input  logic                 first,
  input  logic                 advance,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic                 last_step
);

  logic                 rep_done;
  logic                 hyp;
  logic                 repeat_due;
  logic [CNT_WIDTH-1:0] last_idx;

  assign hyp        = (coord == COORD_HYP);
  assign repeat_due = hyp && is_hyp_repeat(int'(iter_count)) && !rep_done;
  assign last_idx   = ((coord == COORD_LIN) || (coord == COORD_CIRC)) ?
                      CNT_WIDTH'(NUM_ITER - 1) : CNT_WIDTH'(NUM_ITER);
  assign last_step  = (iter_count == last_idx) && !repeat_due;

  // A repeat index holds the count for one extra step, then resumes counting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_count <= '0;
      rep_done   <= 1'b0;
    end else if (first) begin
      iter_count <= hyp ? CNT_WIDTH'(1) : '0;
      rep_done   <= 1'b0;
    end else if (advance && !last_step) begin
      if (repeat_due) begin
        rep_done <= 1'b1;
      end else begin
        iter_count <= iter_count + CNT_WIDTH'(1);
        rep_done   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - command, load, iterate and result handshake control for the CORDIC datapath
module cordic_sequencer
  import cordic_ctrl_pkg::*;
#(
  parameter int NUM_ITER  = 8,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 start_ready,
  input  logic                 mode_bit_in,
  input  logic [1:0]           coord_in,
  input  logic                 abort,
  output logic                 load_sel,
  output logic                 reg_en,
  output logic [CNT_WIDTH-1:0] iter_count,
  output logic                 mode_bit_out,
  output logic [1:0]           coord_out,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 cmd_err
);

  seq_state_e state;
  logic       accept;
  logic       idx_first;
  logic       idx_advance;
  logic       last_step;
  logic [1:0] idx_coord;

  assign accept      = start && (state == IDLE);
  assign idx_first   = accept && (coord_in != COORD_ILLEGAL);
  assign idx_advance = (state == ITER) && !abort;
  // The index block must see the incoming coordinate on the accept edge itself.
  assign idx_coord   = accept ? coord_in : coord_out;

  cordic_iter_index #(
    .NUM_ITER  (NUM_ITER),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_iter_index (
    .clk        (clk),
    .rst        (rst),
    .coord      (idx_coord),
    .first      (idx_first),
    .advance    (idx_advance),
    .iter_count (iter_count),
    .last_step  (last_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      start_ready  <= 1'b1;
      load_sel     <= 1'b0;
      reg_en       <= 1'b0;
      mode_bit_out <= 1'b0;
      coord_out    <= COORD_LIN;
      result_valid <= 1'b0;
      cmd_err      <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (coord_in == COORD_ILLEGAL) begin
              cmd_err <= 1'b1;
            end else begin
              state        <= LOAD;
              start_ready  <= 1'b0;
              load_sel     <= 1'b1;
              reg_en       <= 1'b1;
              mode_bit_out <= mode_bit_in;
              coord_out    <= coord_in;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            load_sel    <= 1'b0;
            reg_en      <= 1'b0;
          end else begin
            state    <= ITER;
            load_sel <= 1'b0;
          end
        end
        ITER: begin
          if (abort) begin
            state       <= IDLE;
            start_ready <= 1'b1;
            reg_en      <= 1'b0;
          end else if (last_step) begin
            state        <= DONE;
            reg_en       <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          if (abort || result_ready) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          start_ready  <= 1'b1;
          load_sel     <= 1'b0;
          reg_en       <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
